// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-controller bus: per-stage stall requests and redirect requests from the
// pipeline, with stall/flush, PC-load and counter/watchdog observation going back.
interface pipeline_hazard_unit_if #(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_REDIRECT = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int CNT_WIDTH    = 32
);
    localparam int NUM_CNT = NUM_STAGES + NUM_REDIRECT;
    localparam int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic [NUM_STAGES-1:0]              stall_req;
    logic [NUM_REDIRECT-1:0]            redirect_valid;
    logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_target;
    logic [NUM_STAGES-1:0]              hc_stall;
    logic [NUM_STAGES-1:0]              hc_flush;
    logic                               load_pc_we;
    logic [ADDR_WIDTH-1:0]              load_pc_new_pc;
    logic [SEL_W-1:0]                   cnt_sel;
    logic [CNT_WIDTH-1:0]               cnt_rdata;
    logic                               cnt_clear;
    logic                               deadlock;

    // Pipeline side: raises requests, consumes stall/flush/PC-load.
    modport master (
        output stall_req, redirect_valid, redirect_target, cnt_sel, cnt_clear,
        input  hc_stall, hc_flush, load_pc_we, load_pc_new_pc, cnt_rdata, deadlock
    );

    // Hazard-unit side.
    modport slave (
        input  stall_req, redirect_valid, redirect_target, cnt_sel, cnt_clear,
        output hc_stall, hc_flush, load_pc_we, load_pc_new_pc, cnt_rdata, deadlock
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for an N-stage in-order pipeline: turns per-stage stall
// requests and redirect requests into stall/flush for every pipeline register
// and a PC overload, with saturating hazard counters and a no-retire watchdog.
module pipeline_hazard_unit #(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_REDIRECT = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DELAY_SLOT   = 1,
    parameter int REDIRECT_REG = 0,
    parameter int CNT_WIDTH    = 32,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_hazard_unit_if.slave   bus
);
    localparam int NUM_CNT = NUM_STAGES + NUM_REDIRECT;
    localparam int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam int RIDX_W  = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;
    localparam int WD_W    = $clog2(WDOG_CYCLES + 1);

    logic [NUM_STAGES-1:0]              w_sr;
    logic [NUM_REDIRECT-1:0]            w_rv;
    logic [NUM_REDIRECT*ADDR_WIDTH-1:0] w_rt;
    logic [SEL_W-1:0]                   w_sel;

    logic [NUM_STAGES-1:0]              w_hold;
    logic [NUM_STAGES-1:0]              w_kill;
    logic [NUM_STAGES-1:0]              w_stall;
    logic [NUM_STAGES-1:0]              w_flush;
    logic                               w_win_v;
    logic [RIDX_W-1:0]                  w_win_idx;
    logic [ADDR_WIDTH-1:0]              w_win_tgt;
    logic                               w_act;
    logic [NUM_CNT-1:0]                 w_inc;
    logic [CNT_WIDTH-1:0]               w_rdata;

    logic                               r_rd_v;
    logic [ADDR_WIDTH-1:0]              r_rd_pc;
    logic [CNT_WIDTH-1:0]               r_cnt [NUM_CNT];
    logic [WD_W-1:0]                    r_wd;
    logic                               r_deadlock;

    assign w_sr  = bus.stall_req;
    assign w_rv  = bus.redirect_valid;
    assign w_rt  = bus.redirect_target;
    assign w_sel = bus.cnt_sel;

    // Backpressure: a register holds if its own stage or anything downstream stalls.
    always_comb begin
        w_hold = '0;
        for (int unsigned i = 0; i < NUM_STAGES - 1; i++) begin
            w_hold[NUM_STAGES-2-i] = w_sr[NUM_STAGES-2-i] | w_hold[NUM_STAGES-1-i];
        end
    end

    // Redirect arbitration: the highest valid source (oldest stage) wins.
    always_comb begin
        w_win_v   = 1'b0;
        w_win_idx = '0;
        w_win_tgt = '0;
        for (int unsigned r = 0; r < NUM_REDIRECT; r++) begin
            if (w_rv[r]) begin
                w_win_v   = 1'b1;
                w_win_idx = RIDX_W'(r);
                w_win_tgt = w_rt[r*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Wrong-path kill: registers younger than the winning stage (and the stage
    // itself when there is no delay slot).
    always_comb begin
        int unsigned stage;
        w_kill = '0;
        stage  = 32'(w_win_idx) + 1;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            if (w_win_v) begin
                if (DELAY_SLOT != 0) w_kill[k] = (k < stage);
                else                 w_kill[k] = (k <= stage);
            end
        end
    end

    // Stall/flush outputs; a redirect only overrides IF's own stall, never
    // backpressure from register 1.
    always_comb begin
        w_act    = (REDIRECT_REG != 0) ? r_rd_v : w_win_v;
        w_stall  = w_hold;
        w_stall[0] = w_hold[1] | (w_hold[0] & ~w_act);
        w_flush  = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            w_flush[k] = w_sr[k-1] | w_kill[k];
        end
        if ((REDIRECT_REG != 0) && r_rd_v) begin
            w_flush[1] = 1'b1;
        end
    end

    // Registered-redirect holding flop, overwritten by each cycle's winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v  <= 1'b0;
            r_rd_pc <= '0;
        end else begin
            r_rd_v <= w_win_v;
            if (w_win_v) r_rd_pc <= w_win_tgt;
        end
    end

    // Counter increment sources: per-stage stall requests, then per-source wins.
    always_comb begin
        w_inc = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            w_inc[k] = w_sr[k];
        end
        for (int unsigned r = 0; r < NUM_REDIRECT; r++) begin
            w_inc[NUM_STAGES+r] = w_win_v && (w_win_idx == RIDX_W'(r));
        end
    end

    // Saturating hazard counters; clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (bus.cnt_clear)                     r_cnt[i] <= '0;
                else if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // Counter read port; unmatched selects read zero.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (w_sel == SEL_W'(i)) w_rdata = r_cnt[i];
        end
    end

    // Watchdog: consecutive cycles in which the last non-WB register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (!w_hold[NUM_STAGES-2]) begin
            r_wd <= '0;
        end else if (r_wd != WD_W'(WDOG_CYCLES - 1)) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Sticky deadlock flag, cleared only by cnt_clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deadlock <= 1'b0;
        end else if (bus.cnt_clear) begin
            r_deadlock <= 1'b0;
        end else if (w_hold[NUM_STAGES-2] && (r_wd == WD_W'(WDOG_CYCLES - 1))) begin
            r_deadlock <= 1'b1;
        end
    end

    assign bus.hc_stall       = w_stall;
    assign bus.hc_flush       = w_flush;
    assign bus.load_pc_we     = rst_n & ((REDIRECT_REG != 0) ? r_rd_v : w_win_v);
    assign bus.load_pc_new_pc = (REDIRECT_REG != 0) ? r_rd_pc : w_win_tgt;
    assign bus.cnt_rdata      = w_rdata;
    assign bus.deadlock       = r_deadlock;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: default-parameter instance plus a registered-redirect,
// short-watchdog, 4-bit-counter instance.
module tb_pipeline_hazard_unit;
    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.NUM_STAGES(5), .NUM_REDIRECT(2), .ADDR_WIDTH(32), .CNT_WIDTH(32)) i0 ();
    pipeline_hazard_unit_if #(.NUM_STAGES(5), .NUM_REDIRECT(2), .ADDR_WIDTH(32), .CNT_WIDTH(4))  i1 ();

    pipeline_hazard_unit #(
        .NUM_STAGES(5), .NUM_REDIRECT(2), .ADDR_WIDTH(32), .DELAY_SLOT(1),
        .REDIRECT_REG(0), .CNT_WIDTH(32), .WDOG_CYCLES(1024)
    ) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(i0)
    );

    pipeline_hazard_unit #(
        .NUM_STAGES(5), .NUM_REDIRECT(2), .ADDR_WIDTH(32), .DELAY_SLOT(1),
        .REDIRECT_REG(1), .CNT_WIDTH(4), .WDOG_CYCLES(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(i1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i0.stall_req = '0; i0.redirect_valid = '0; i0.redirect_target = '0;
        i0.cnt_sel = '0; i0.cnt_clear = 1'b0;
        i1.stall_req = '0; i1.redirect_valid = '0; i1.redirect_target = '0;
        i1.cnt_sel = '0; i1.cnt_clear = 1'b0;

        // reset
        @(negedge clk); @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;
        #1;
        chk("rst_cnt0", i0.cnt_rdata, 0);
        chk("rst_dl0", i0.deadlock, 0);
        chk("rst_we0", i0.load_pc_we, 0);
        chk("rst_cnt1", i1.cnt_rdata, 0);

        // stage-3 stall for 3 cycles
        @(negedge clk);
        i0.stall_req = 5'b01000;
        #1;
        chk("s3_stall", i0.hc_stall, 5'h0F);
        chk("s3_flush", i0.hc_flush, 5'h10);
        repeat (3) @(negedge clk);
        i0.stall_req = '0; i0.cnt_sel = 3;
        #1;
        chk("s3_cnt", i0.cnt_rdata, 3);

        // IF miss overridden by redirect from source 1
        i0.stall_req = 5'b00001; i0.redirect_valid = 2'b10;
        i0.redirect_target = {32'h0000_0400, 32'h0};
        #1;
        chk("r1_stall", i0.hc_stall, 5'h00);
        chk("r1_flush", i0.hc_flush, 5'h02);
        chk("r1_we", i0.load_pc_we, 1);
        chk("r1_pc", i0.load_pc_new_pc, 32'h400);
        @(negedge clk);
        i0.stall_req = '0; i0.redirect_valid = '0; i0.cnt_sel = 6;
        #1;
        chk("r1_cnt6", i0.cnt_rdata, 1);
        i0.cnt_sel = 0;
        #1;
        chk("r1_cnt0", i0.cnt_rdata, 1);

        // both sources valid: source 1 wins
        i0.redirect_valid = 2'b11; i0.redirect_target = {32'h0000_0200, 32'h0000_0100};
        i0.cnt_sel = 5;
        #1;
        chk("both_pc", i0.load_pc_new_pc, 32'h200);
        chk("both_flush", i0.hc_flush, 5'h02);
        chk("both_cnt5_pre", i0.cnt_rdata, 0);
        @(negedge clk);
        i0.redirect_valid = '0; i0.cnt_sel = 6;
        #1;
        chk("both_cnt6", i0.cnt_rdata, 2);
        i0.cnt_sel = 5;
        #1;
        chk("both_cnt5", i0.cnt_rdata, 0);

        // source 0 alone: delay slot means nothing is killed
        i0.redirect_valid = 2'b01;
        #1;
        chk("r0_we", i0.load_pc_we, 1);
        chk("r0_pc", i0.load_pc_new_pc, 32'h100);
        chk("r0_flush", i0.hc_flush, 5'h00);
        @(negedge clk);
        i0.redirect_valid = '0;
        #1;
        chk("r0_cnt5", i0.cnt_rdata, 1);

        // backpressure from reg 1 keeps IF stalled despite redirect
        i0.stall_req = 5'b00010; i0.redirect_valid = 2'b01;
        #1;
        chk("h1_stall", i0.hc_stall, 5'h03);
        chk("h1_flush", i0.hc_flush, 5'h04);
        chk("h1_we", i0.load_pc_we, 1);
        @(negedge clk);
        i0.stall_req = '0; i0.redirect_valid = '0; i0.cnt_sel = 7;
        #1;
        chk("oor_sel", i0.cnt_rdata, 0);

        // clear coincident with increment
        i0.stall_req = 5'b01000; i0.cnt_clear = 1'b1;
        @(negedge clk);
        i0.stall_req = '0; i0.cnt_clear = 1'b0; i0.cnt_sel = 3;
        #1;
        chk("clr_cnt3", i0.cnt_rdata, 0);
        i0.cnt_sel = 6;
        #1;
        chk("clr_cnt6", i0.cnt_rdata, 0);

        // async reset mid-redirect
        i0.stall_req = 5'b01000; i0.redirect_valid = 2'b10;
        i0.redirect_target = {32'h0000_0400, 32'h0};
        #1;
        chk("mr_we_pre", i0.load_pc_we, 1);
        rst0_n = 1'b0;
        #1;
        chk("mr_we", i0.load_pc_we, 0);
        chk("mr_flush", i0.hc_flush, 5'h12);
        chk("mr_stall", i0.hc_stall, 5'h0F);
        @(negedge clk);
        i0.stall_req = '0; i0.redirect_valid = '0;
        rst0_n = 1'b1;

        // registered redirect, source 0
        @(negedge clk);
        i1.redirect_valid = 2'b01; i1.redirect_target = {32'h0000_0800, 32'h0000_0300};
        #1;
        chk("rr0_we_t", i1.load_pc_we, 0);
        chk("rr0_flush_t", i1.hc_flush, 5'h00);
        @(negedge clk);
        i1.redirect_valid = '0;
        #1;
        chk("rr0_we_t1", i1.load_pc_we, 1);
        chk("rr0_pc_t1", i1.load_pc_new_pc, 32'h300);
        chk("rr0_flush_t1", i1.hc_flush, 5'h02);
        @(negedge clk);
        #1;
        chk("rr0_we_t2", i1.load_pc_we, 0);
        chk("rr0_flush_t2", i1.hc_flush, 5'h00);

        // registered redirect, source 1: kill applies in the capture cycle
        i1.redirect_valid = 2'b10;
        #1;
        chk("rr1_flush_t", i1.hc_flush, 5'h02);
        chk("rr1_we_t", i1.load_pc_we, 0);
        @(negedge clk);
        i1.redirect_valid = '0;
        #1;
        chk("rr1_we_t1", i1.load_pc_we, 1);
        chk("rr1_pc_t1", i1.load_pc_new_pc, 32'h800);

        // watchdog with WDOG_CYCLES=8
        @(negedge clk);
        i1.stall_req = 5'b01000;
        repeat (7) @(negedge clk);
        #1;
        chk("wd_7", i1.deadlock, 0);
        @(negedge clk);
        #1;
        chk("wd_8", i1.deadlock, 1);
        i1.stall_req = '0;
        @(negedge clk);
        i1.cnt_sel = 3;
        #1;
        chk("wd_sticky", i1.deadlock, 1);
        chk("wd_cnt3", i1.cnt_rdata, 8);
        i1.cnt_clear = 1'b1;
        @(negedge clk);
        i1.cnt_clear = 1'b0;
        #1;
        chk("wd_clr_dl", i1.deadlock, 0);
        chk("wd_clr_cnt3", i1.cnt_rdata, 0);

        // 4-bit counter saturation
        i1.stall_req = 5'b01010;
        repeat (20) @(negedge clk);
        i1.cnt_sel = 1;
        #1;
        chk("sat_cnt1", i1.cnt_rdata, 15);
        i1.cnt_sel = 3;
        #1;
        chk("sat_cnt3", i1.cnt_rdata, 15);
        chk("sat_dl", i1.deadlock, 1);

        // async reset with a registered redirect pending
        i1.redirect_valid = 2'b01;
        @(negedge clk);
        i1.redirect_valid = '0;
        #1;
        chk("rst1_we_pre", i1.load_pc_we, 1);
        rst1_n = 1'b0;
        i1.cnt_sel = 1;
        #1;
        chk("rst1_we", i1.load_pc_we, 0);
        chk("rst1_cnt1", i1.cnt_rdata, 0);
        chk("rst1_dl", i1.deadlock, 0);
        i1.stall_req = '0;
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst1_cnt1", i1.cnt_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
